// File: rtl/snitch_tcdm_pkg.sv
// Shared types and constants for the TCDM bank arbiter slice.
package snitch_tcdm_pkg;

   localparam int unsigned TcdmNumReq    = 4;
   localparam int unsigned TcdmDepth     = 512;
   localparam int unsigned TcdmDataWidth = 64;
   localparam int unsigned TcdmAddrWidth = $clog2(TcdmDepth);

   // Requester index width; a single requester still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
   endfunction

   localparam int unsigned IdxWidth = idx_width(TcdmNumReq);

   typedef enum logic {
      INIT,
      RUN
   } arb_state_e;

   // Payload of the winning requester as presented to the bank.
   typedef struct packed {
      logic                         we;
      logic [TcdmAddrWidth-1:0]     addr;
      logic [TcdmDataWidth/8-1:0]   be;
      logic [TcdmDataWidth-1:0]     wdata;
   } bank_req_t;

endpackage

// File: rtl/snitch_rr_arbiter.sv
// Round-robin pick over NumReq requests with a registered priority pointer.
module snitch_rr_arbiter
   import snitch_tcdm_pkg::*;
#(
   parameter int unsigned NumReq = TcdmNumReq,
   localparam int unsigned IdxW  = idx_width(NumReq)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NumReq-1:0] req,
   output logic [NumReq-1:0] gnt_c,
   output logic [IdxW-1:0]   idx_c
);

   logic [IdxW-1:0] ptr_q;
   logic [IdxW:0]   cand;
   logic            found;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = {1'b0, ptr_q} + (IdxW+1)'(k);
         if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
         if (!found && req[cand[IdxW-1:0]]) begin
            found = 1'b1;
            idx_c = cand[IdxW-1:0];
         end
      end
      if (found) gnt_c = NumReq'(1) << idx_c;
   end

   // Pointer moves just past the winner on every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en) begin
         ptr_q <= (idx_c == IdxW'(NumReq-1)) ? '0 : idx_c + 1'b1;
      end
   end

endmodule

// File: rtl/snitch_tcdm_bank_arbiter.sv
// Shares one single-port TCDM bank between NumReq requesters, with optional
// zero-fill of the bank after reset.
module snitch_tcdm_bank_arbiter
   import snitch_tcdm_pkg::*;
#(
   parameter int unsigned NumReq       = TcdmNumReq,
   parameter int unsigned TCDMDepth    = TcdmDepth,
   parameter int unsigned DataWidth    = TcdmDataWidth,
   parameter bit          ClearOnReset = 1'b1,
   parameter int unsigned AddrWidth    = $clog2(TCDMDepth)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumReq-1:0]               req_i,
   input  logic [NumReq-1:0]               we_i,
   input  logic [NumReq*AddrWidth-1:0]     addr_i,
   input  logic [NumReq*(DataWidth/8)-1:0] be_i,
   input  logic [NumReq*DataWidth-1:0]     wdata_i,
   output logic [NumReq-1:0]               gnt_o,
   output logic [NumReq-1:0]               rvalid_o,
   output logic [DataWidth-1:0]            rdata_o,
   output logic                            init_done_o,
   output logic                            mem_cs_o,
   output logic                            mem_wen_o,
   output logic [AddrWidth-1:0]            mem_add_o,
   output logic [DataWidth/8-1:0]          mem_be_o,
   output logic [DataWidth-1:0]            mem_wdata_o,
   input  logic [DataWidth-1:0]            mem_rdata_i
);

   localparam int unsigned IdxW    = idx_width(NumReq);
   localparam int unsigned BeWidth = DataWidth / 8;

   arb_state_e      state_q;
   logic [AddrWidth:0] clr_addr_q;
   logic [AddrWidth:0] clr_next;
   logic            init_done_q;
   logic            valid_q;
   logic [IdxW-1:0] idx_q;
   logic [NumReq-1:0] arb_gnt;
   logic [IdxW-1:0] win_idx;
   logic            arb_en;
   bank_req_t       win_req;

   assign arb_en   = (state_q == RUN) && !rst_i && (|req_i);
   assign clr_next = clr_addr_q + 1'b1;

   snitch_rr_arbiter #(
      .NumReq (NumReq)
   ) i_rr_arbiter (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (arb_en),
      .req   (req_i),
      .gnt_c (arb_gnt),
      .idx_c (win_idx)
   );

   // Select the winning requester's payload.
   always_comb begin
      win_req       = '0;
      win_req.we    = we_i[win_idx];
      win_req.addr  = addr_i[win_idx*AddrWidth +: AddrWidth];
      win_req.be    = be_i[win_idx*BeWidth +: BeWidth];
      win_req.wdata = wdata_i[win_idx*DataWidth +: DataWidth];
   end

   // Bank port and grant: clear sweep in INIT, winner pass-through in RUN.
   always_comb begin
      gnt_o       = '0;
      mem_cs_o    = 1'b0;
      mem_wen_o   = 1'b0;
      mem_add_o   = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (!rst_i) begin
         unique case (state_q)
            INIT: begin
               mem_cs_o    = 1'b1;
               mem_wen_o   = 1'b1;
               mem_add_o   = clr_addr_q[AddrWidth-1:0];
               mem_be_o    = '1;
               mem_wdata_o = '0;
            end
            RUN: begin
               gnt_o       = arb_gnt;
               mem_cs_o    = |req_i;
               mem_wen_o   = win_req.we;
               mem_add_o   = win_req.addr;
               mem_be_o    = win_req.be;
               mem_wdata_o = win_req.wdata;
            end
            default: ;
         endcase
      end
   end

   // Response valid is decoded from the registered winner; reset masks it.
   always_comb begin
      rvalid_o = '0;
      if (valid_q && !rst_i) rvalid_o[idx_q] = 1'b1;
   end

   assign rdata_o     = mem_rdata_i;
   assign init_done_o = init_done_q;

   // Sweep/run state, clear address and response tracking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ClearOnReset ? INIT : RUN;
         clr_addr_q  <= '0;
         init_done_q <= !ClearOnReset;
         valid_q     <= 1'b0;
         idx_q       <= '0;
      end else begin
         valid_q <= arb_en;
         idx_q   <= win_idx;
         unique case (state_q)
            INIT: begin
               clr_addr_q <= clr_next;
               if (clr_next == (AddrWidth+1)'(TCDMDepth)) begin
                  state_q     <= RUN;
                  init_done_q <= 1'b1;
               end
            end
            RUN: ;
            default: state_q <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_snitch_tcdm_bank_arbiter.sv
// Self-checking bench for snitch_tcdm_bank_arbiter with an SRAM macro model
// and a transaction-level reference of arbitration and bank contents.
module tb_snitch_tcdm_bank_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned DEPTH = 512;
   localparam int unsigned DW    = 64;
   localparam int unsigned AW    = 9;
   localparam int unsigned BW    = DW / 8;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [N*AW-1:0] addr;
   logic [N*BW-1:0] be;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic            init_done;
   logic            mem_cs;
   logic            mem_wen;
   logic [AW-1:0]   mem_add;
   logic [BW-1:0]   mem_be;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   snitch_tcdm_bank_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .we_i        (we),
      .addr_i      (addr),
      .be_i        (be),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .init_done_o (init_done),
      .mem_cs_o    (mem_cs),
      .mem_wen_o   (mem_wen),
      .mem_add_o   (mem_add),
      .mem_be_o    (mem_be),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM macro: port sampled mid-cycle, applied at the clock edge.
   logic [DW-1:0] sram [DEPTH];
   initial begin
      logic          s_cs, s_wen;
      logic [AW-1:0] s_add;
      logic [BW-1:0] s_be;
      logic [DW-1:0] s_wd;
      for (int i = 0; i < int'(DEPTH); i++) sram[i] = {$urandom, $urandom};
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         s_cs = mem_cs; s_wen = mem_wen; s_add = mem_add; s_be = mem_be; s_wd = mem_wdata;
         @(posedge clk);
         if (s_cs) begin
            if (s_wen) begin
               for (int b = 0; b < int'(BW); b++)
                  if (s_be[b]) sram[s_add][8*b +: 8] = s_wd[8*b +: 8];
            end else begin
               mem_rdata = sram[s_add];
            end
         end
      end
   end

   // Reference model state
   int            tests, fails;
   int            ptr, sweep_cnt, pend_idx, max_wait;
   bit            model_run, pend_valid, pend_read;
   logic [DW-1:0] pend_data;
   logic [DW-1:0] ref_mem [DEPTH];
   int            waitc [N];
   logic [N-1:0]  last_gnt, last_rvalid;
   logic [DW-1:0] last_rdata;
   logic [AW-1:0] last_mem_add;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [BW-1:0] b, input logic [DW-1:0] d);
      req[i]            = r;
      we[i]             = w;
      addr[i*AW +: AW]  = a;
      be[i*BW +: BW]    = b;
      wdata[i*DW +: DW] = d;
   endtask

   // One clock: compare DUT against the model mid-cycle, then advance the model.
   task automatic cycle();
      int            win;
      logic [N-1:0]  exp_gnt, exp_rv;
      logic [AW-1:0] a;
      @(negedge clk);
      check("init_done", 64'(init_done), 64'(model_run));
      exp_rv = '0;
      if (pend_valid && !rst) exp_rv[pend_idx] = 1'b1;
      check("rvalid", 64'(rvalid), 64'(exp_rv));
      if (pend_valid && pend_read && !rst) check("rdata", rdata, pend_data);
      pend_valid = 1'b0;
      if (rst) begin
         check("gnt_in_reset", 64'(gnt), 64'd0);
         check("cs_in_reset", 64'(mem_cs), 64'd0);
         ptr = 0; sweep_cnt = 0; model_run = 1'b0;
      end else if (!model_run) begin
         check("gnt_in_init", 64'(gnt), 64'd0);
         check("sweep_cs", 64'(mem_cs), 64'd1);
         check("sweep_wen", 64'(mem_wen), 64'd1);
         check("sweep_add", 64'(mem_add), 64'(sweep_cnt));
         check("sweep_be", 64'(mem_be), 64'hFF);
         check("sweep_wdata", mem_wdata, 64'd0);
         sweep_cnt++;
         if (sweep_cnt == int'(DEPTH)) begin
            model_run = 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
         end
      end else begin
         win = -1;
         for (int k = 0; k < int'(N); k++)
            if (win < 0 && req[(ptr + k) % int'(N)]) win = (ptr + k) % int'(N);
         exp_gnt = '0;
         if (win >= 0) exp_gnt[win] = 1'b1;
         check("gnt", 64'(gnt), 64'(exp_gnt));
         check("mem_cs", 64'(mem_cs), 64'(win >= 0));
         if (win >= 0) begin
            a = addr[win*AW +: AW];
            check("mem_wen", 64'(mem_wen), 64'(we[win]));
            check("mem_add", 64'(mem_add), 64'(a));
            check("mem_be", 64'(mem_be), 64'(be[win*BW +: BW]));
            check("mem_wdata", mem_wdata, wdata[win*DW +: DW]);
            pend_valid = 1'b1;
            pend_idx   = win;
            pend_read  = !we[win];
            pend_data  = ref_mem[a];
            if (we[win])
               for (int b = 0; b < int'(BW); b++)
                  if (be[win*BW + b]) ref_mem[a][8*b +: 8] = wdata[win*DW + 8*b +: 8];
            ptr = (win + 1) % int'(N);
         end
         for (int i = 0; i < int'(N); i++) begin
            if (req[i] && !gnt[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > max_wait) max_wait = waitc[i];
         end
      end
      last_gnt     = gnt;
      last_rvalid  = rvalid;
      last_rdata   = rdata;
      last_mem_add = mem_add;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [AW-1:0] nxt [N];
      tests = 0; fails = 0;
      ptr = 0; sweep_cnt = 0; pend_idx = 0; max_wait = 0;
      model_run = 1'b0; pend_valid = 1'b0; pend_read = 1'b0; pend_data = '0;
      for (int i = 0; i < int'(N); i++) waitc[i] = 0;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
      rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;

      // Reset, then full sweep with requester 0 holding a read of addr 3
      set_req(0, 1'b1, 1'b0, 9'd3, 8'hFF, 64'd0);
      cycle(); cycle();
      rst = 1'b0;
      repeat (DEPTH) cycle();
      cycle();
      check("first_gnt_after_sweep", 64'(last_gnt), 64'h1);
      req[0] = 1'b0;
      cycle();
      check("cleared_word", last_rdata, 64'd0);

      // Full write then read back
      set_req(0, 1'b1, 1'b1, 9'd5, 8'hFF, 64'hDEADBEEF_CAFEF00D);
      cycle();
      set_req(0, 1'b1, 1'b0, 9'd5, 8'hFF, 64'd0);
      cycle();
      check("write_ack", 64'(last_rvalid), 64'h1);
      req[0] = 1'b0;
      cycle();
      check("readback", last_rdata, 64'hDEADBEEF_CAFEF00D);

      // Partial byte-enable write
      set_req(0, 1'b1, 1'b1, 9'd7, 8'h0F, 64'h11223344_55667788);
      cycle();
      set_req(0, 1'b1, 1'b0, 9'd7, 8'hFF, 64'd0);
      cycle();
      req[0] = 1'b0;
      cycle();
      check("be_merge", last_rdata, 64'h00000000_55667788);

      // Fill addresses 40..71 with distinct data, back-to-back from one requester
      for (int a = 40; a < 72; a++) begin
         set_req(0, 1'b1, 1'b1, AW'(a), 8'hFF, {$urandom, $urandom});
         cycle();
      end
      req = '0;

      // Full contention: all requesters read continuously
      for (int i = 0; i < int'(N); i++) begin
         nxt[i] = AW'(40 + 8*i);
         set_req(i, 1'b1, 1'b0, nxt[i], 8'hFF, 64'd0);
         waitc[i] = 0;
      end
      max_wait = 0;
      repeat (16) begin
         cycle();
         for (int i = 0; i < int'(N); i++)
            if (last_gnt[i]) begin
               nxt[i] = nxt[i] + 1'b1;
               set_req(i, 1'b1, 1'b0, nxt[i], 8'hFF, 64'd0);
            end
      end
      req = '0;
      cycle();
      check("max_wait", 64'(max_wait), 64'd3);

      // Sparse contention after requester 2 moves the pointer to 3
      set_req(2, 1'b1, 1'b0, 9'd41, 8'hFF, 64'd0);
      cycle();
      req[2] = 1'b0;
      set_req(1, 1'b1, 1'b0, 9'd42, 8'hFF, 64'd0);
      set_req(3, 1'b1, 1'b0, 9'd43, 8'hFF, 64'd0);
      cycle();
      check("sparse_first", 64'(last_gnt), 64'h8);
      req[3] = 1'b0;
      cycle();
      check("sparse_second", 64'(last_gnt), 64'h2);
      req = '0;
      cycle();

      // Reset right after a grant, then again in the middle of the sweep
      set_req(1, 1'b1, 1'b0, 9'd44, 8'hFF, 64'd0);
      cycle();
      check("gnt_before_reset", 64'(last_gnt), 64'h2);
      req = '0;
      rst = 1'b1;
      cycle();
      check("no_rvalid_in_reset", 64'(last_rvalid), 64'd0);
      rst = 1'b0;
      cycle();
      check("no_rvalid_after_reset", 64'(last_rvalid), 64'd0);
      repeat (99) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cycle();
      check("sweep_restart", 64'(last_mem_add), 64'd0);
      repeat (DEPTH - 1) cycle();

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < int'(N); i++)
            if (!req[i] || last_gnt[i]) begin
               if ($urandom_range(3, 0) != 0)
                  set_req(i, 1'b1, 1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)),
                          BW'($urandom_range(255, 0)), {$urandom, $urandom});
               else
                  req[i] = 1'b0;
            end
         cycle();
      end
      req = '0;
      cycle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
